if_stage: RTL and testbench

//  Instruction-fetch stage of the 16-bit MIPS pipeline; feeds the decode stage of main_module.

---
 rtl/mips16_pkg.sv | 32 +++
 rtl/if_stage_if.sv | 19 +
 rtl/if_stage_pc_next_mux.sv | 71 +++++++
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips16_pkg.sv
// Shared types and constants for the 16-bit MIPS pipeline.
// Fetch-side widths, vectors, next-PC select codes and the IF/ID bundle.
package mips16_pkg;

  localparam int PC_W  = 16;
  localparam int INS_W = 32;

  localparam logic [INS_W-1:0] NOP_INS   = '0;
  localparam logic [PC_W-1:0]  RESET_VEC = 16'h0000;
  localparam logic [PC_W-1:0]  INT_VEC   = 16'h0040;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BR,
    SEL_EPC,
    SEL_INT
  } pc_sel_e;

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [PC_W-1:0]  pc1;
    logic             valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    ins:   NOP_INS,
    pc1:   '0,
    valid: 1'b0
  };

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port between the fetch stage and imem.
// Address out, read data back in the same cycle.
interface if_stage_if;
  import mips16_pkg::*;

  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/if_stage_pc_next_mux.sv
// Priority select of the next PC plus IF/ID bubble/hold control.
// Arms are made mutually exclusive so the decoder can be unique.
module pc_next_mux
  import mips16_pkg::*;
#(
  parameter logic [PC_W-1:0] INT_ADDR = INT_VEC
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic [PC_W-1:0] epc_i,
  input  logic            int_active_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            pc_mux_sel_i,
  input  logic            interrupt_i,
  input  logic            eret_i,
  output pc_sel_e         sel_o,
  output logic [PC_W-1:0] pc_d_o,
  output logic [PC_W-1:0] pc_plus1_o,
  output logic            bubble_o,
  output logic            hold_o
);

  logic int_take;
  logic br_take;
  logic ret_take;
  logic stl_take;

  always_comb begin
    int_take = interrupt_i & ~int_active_i
             & ~eret_i & ~stall_i;
    br_take  = pc_mux_sel_i & ~int_take;
    ret_take = eret_i & int_active_i
             & ~int_take & ~pc_mux_sel_i;
    stl_take = stall_i & ~int_take
             & ~pc_mux_sel_i & ~ret_take;
  end

  always_comb begin
    pc_plus1_o = pc_i + PC_W'(1);
    sel_o      = SEL_SEQ;
    pc_d_o     = pc_plus1_o;
    bubble_o   = flush_i;
    hold_o     = 1'b0;
    unique case (1'b1)
      int_take: begin
        sel_o    = SEL_INT;
        pc_d_o   = INT_ADDR;
        bubble_o = 1'b1;
      end
      br_take: begin
        sel_o    = SEL_BR;
        pc_d_o   = branch_target_i;
        bubble_o = 1'b1;
      end
      ret_take: begin
        sel_o    = SEL_EPC;
        pc_d_o   = epc_i;
        bubble_o = 1'b1;
      end
      stl_take: begin
        sel_o    = SEL_HOLD;
        pc_d_o   = pc_i;
        bubble_o = flush_i;
        hold_o   = ~flush_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, IF/ID latch, EPC and interrupt state.
// Next-PC choice lives in pc_next_mux; this module only registers it.
module if_stage
  import mips16_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC = mips16_pkg::RESET_VEC,
  parameter logic [PC_W-1:0] INT_VEC   = mips16_pkg::INT_VEC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              pc_mux_sel,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              interrupt,
  input  logic              eret,
  if_stage_if.master        imem,
  output logic [PC_W-1:0]   current_address,
  output logic [INS_W-1:0]  if_id_ins,
  output logic [PC_W-1:0]   if_id_pc1,
  output logic              if_id_valid,
  output logic [PC_W-1:0]   epc,
  output logic              int_active
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            ia_q, ia_d;
  if_id_t          ifid_q, ifid_d;

  pc_sel_e         sel;
  logic [PC_W-1:0] pc_plus1;
  logic            bubble;
  logic            hold;

  pc_next_mux #(
    .INT_ADDR(INT_VEC)
  ) u_mux (
    .pc_i           (pc_q),
    .branch_target_i(branch_target),
    .epc_i          (epc_q),
    .int_active_i   (ia_q),
    .stall_i        (stall),
    .flush_i        (flush),
    .pc_mux_sel_i   (pc_mux_sel),
    .interrupt_i    (interrupt),
    .eret_i         (eret),
    .sel_o          (sel),
    .pc_d_o         (pc_d),
    .pc_plus1_o     (pc_plus1),
    .bubble_o       (bubble),
    .hold_o         (hold)
  );

  // A redirect in the interrupted cycle is replayed after eret.
  always_comb begin
    epc_d = epc_q;
    ia_d  = ia_q;
    if (sel == SEL_INT) begin
      epc_d = pc_mux_sel ? branch_target : pc_q;
      ia_d  = 1'b1;
    end else if (sel == SEL_EPC) begin
      ia_d  = 1'b0;
    end
  end

  always_comb begin
    ifid_d = '{
      ins:   imem.imem_rdata,
      pc1:   pc_plus1,
      valid: 1'b1
    };
    if (bubble) begin
      ifid_d = IF_ID_BUBBLE;
    end else if (hold) begin
      ifid_d = ifid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_VEC;
      epc_q  <= '0;
      ia_q   <= 1'b0;
      ifid_q <= IF_ID_BUBBLE;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      ia_q   <= ia_d;
      ifid_q <= ifid_d;
    end
  end

  assign imem.imem_addr  = pc_q;
  assign current_address = pc_q;
  assign if_id_ins       = ifid_q.ins;
  assign if_id_pc1       = ifid_q.pc1;
  assign if_id_valid     = ifid_q.valid;
  assign epc             = epc_q;
  assign int_active      = ia_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a cycle-level reference model.
// imem returns {16'hC0DE, addr} so every fetched word names its address.
module tb_if_stage;
  import mips16_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             flush;
  logic             pc_mux_sel;
  logic [PC_W-1:0]  branch_target;
  logic             interrupt;
  logic             eret;
  logic [PC_W-1:0]  current_address;
  logic [INS_W-1:0] if_id_ins;
  logic [PC_W-1:0]  if_id_pc1;
  logic             if_id_valid;
  logic [PC_W-1:0]  epc;
  logic             int_active;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  if_stage_if bus ();

  assign bus.imem_rdata = {16'hC0DE, bus.imem_addr};

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .pc_mux_sel     (pc_mux_sel),
    .branch_target  (branch_target),
    .interrupt      (interrupt),
    .eret           (eret),
    .imem           (bus.master),
    .current_address(current_address),
    .if_id_ins      (if_id_ins),
    .if_id_pc1      (if_id_pc1),
    .if_id_valid    (if_id_valid),
    .epc            (epc),
    .int_active     (int_active)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: architectural state stepped by the rule list.
  logic [15:0] m_pc, m_epc, m_pc1;
  logic [31:0] m_ins;
  logic        m_ia, m_v;

  always @(posedge clk) begin
    if (reset) begin
      m_pc <= 16'h0000; m_epc <= 16'h0000; m_ia <= 1'b0;
      m_ins <= 32'h0; m_pc1 <= 16'h0; m_v <= 1'b0;
    end else if (interrupt && !m_ia && !eret && !stall) begin
      m_epc <= pc_mux_sel ? branch_target : m_pc;
      m_pc <= 16'h0040; m_ia <= 1'b1;
      m_ins <= 32'h0; m_pc1 <= 16'h0; m_v <= 1'b0;
    end else if (pc_mux_sel) begin
      m_pc <= branch_target;
      m_ins <= 32'h0; m_pc1 <= 16'h0; m_v <= 1'b0;
    end else if (eret && m_ia) begin
      m_pc <= m_epc; m_ia <= 1'b0;
      m_ins <= 32'h0; m_pc1 <= 16'h0; m_v <= 1'b0;
    end else if (stall) begin
      if (flush) begin
        m_ins <= 32'h0; m_pc1 <= 16'h0; m_v <= 1'b0;
      end
    end else begin
      m_pc <= m_pc + 16'd1;
      if (flush) begin
        m_ins <= 32'h0; m_pc1 <= 16'h0; m_v <= 1'b0;
      end else begin
        m_ins <= mem(m_pc); m_pc1 <= m_pc + 16'd1; m_v <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      chk("pc",        32'(current_address), 32'(m_pc));
      chk("imem_addr", 32'(bus.imem_addr),   32'(m_pc));
      chk("ins",       if_id_ins,            m_ins);
      chk("pc1",       32'(if_id_pc1),       32'(m_pc1));
      chk("valid",     32'(if_id_valid),     32'(m_v));
      chk("epc",       32'(epc),             32'(m_epc));
      chk("ia",        32'(int_active),      32'(m_ia));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    pc_mux_sel = 1'b0; branch_target = '0;
    interrupt = 1'b0; eret = 1'b0;
    chk_en = 1'b1;

    cyc();
    chk("rst_pc",    32'(current_address), 32'h0);
    chk("rst_valid", 32'(if_id_valid),     32'h0);
    chk("rst_ins",   if_id_ins,            32'h0);
    chk("rst_epc",   32'(epc),             32'h0);
    chk("rst_ia",    32'(int_active),      32'h0);
    reset = 1'b0;

    cyc();
    chk("seq1_pc",    32'(current_address), 32'h1);
    chk("seq1_ins",   if_id_ins,            32'hC0DE_0000);
    chk("seq1_valid", 32'(if_id_valid),     32'h1);
    cyc(2);
    chk("seq3_pc",  32'(current_address), 32'h3);
    chk("seq3_ins", if_id_ins,            32'hC0DE_0002);
    cyc(2);
    chk("pc5", 32'(current_address), 32'h5);

    stall = 1'b1;
    cyc(2);
    chk("stall_pc",  32'(current_address), 32'h5);
    chk("stall_ins", if_id_ins,            32'hC0DE_0004);
    chk("stall_pc1", 32'(if_id_pc1),       32'h5);
    stall = 1'b0;
    cyc();
    chk("unstall_pc",  32'(current_address), 32'h6);
    chk("unstall_ins", if_id_ins,            32'hC0DE_0005);

    cyc(2);
    pc_mux_sel = 1'b1; branch_target = 16'h0020; stall = 1'b1;
    cyc();
    chk("br_pc",    32'(current_address), 32'h20);
    chk("br_valid", 32'(if_id_valid),     32'h0);
    chk("br_ins",   if_id_ins,            32'h0);
    branch_target = 16'h0010; stall = 1'b0;
    cyc();
    pc_mux_sel = 1'b0;

    interrupt = 1'b1;
    cyc();
    chk("int_pc",  32'(current_address), 32'h40);
    chk("int_epc", 32'(epc),             32'h10);
    chk("int_ia",  32'(int_active),      32'h1);
    cyc(5);
    chk("noreent_pc", 32'(current_address), 32'h45);
    interrupt = 1'b0; eret = 1'b1;
    cyc();
    chk("eret_pc", 32'(current_address), 32'h10);
    chk("eret_ia", 32'(int_active),      32'h0);
    eret = 1'b0;

    interrupt = 1'b1; pc_mux_sel = 1'b1; branch_target = 16'h0030;
    cyc();
    chk("intbr_pc",  32'(current_address), 32'h40);
    chk("intbr_epc", 32'(epc),             32'h30);
    pc_mux_sel = 1'b0;
    eret = 1'b1;
    cyc();
    chk("ereti_pc", 32'(current_address), 32'h30);
    chk("ereti_ia", 32'(int_active),      32'h0);
    eret = 1'b0;
    cyc();
    chk("late_int_pc", 32'(current_address), 32'h40);
    interrupt = 1'b0; eret = 1'b1;
    cyc();
    cyc();
    chk("eret_nop_pc",  32'(current_address), 32'h31);
    chk("eret_nop_ins", if_id_ins,            32'hC0DE_0030);
    eret = 1'b0;

    flush = 1'b1;
    cyc();
    chk("flush_pc",    32'(current_address), 32'h32);
    chk("flush_valid", 32'(if_id_valid),     32'h0);
    stall = 1'b1;
    cyc();
    chk("flst_pc", 32'(current_address), 32'h32);
    flush = 1'b0;

    interrupt = 1'b1;
    cyc();
    chk("defer_ia", 32'(int_active), 32'h0);
    stall = 1'b0;
    cyc();
    chk("defer_epc", 32'(epc), 32'h32);
    interrupt = 1'b0; eret = 1'b1;
    cyc();
    eret = 1'b0;

    pc_mux_sel = 1'b1; branch_target = 16'hFFFF;
    cyc();
    pc_mux_sel = 1'b0;
    cyc();
    chk("wrap_pc",  32'(current_address), 32'h0);
    chk("wrap_pc1", 32'(if_id_pc1),       32'h0);
    chk("wrap_ins", if_id_ins,            32'hC0DE_FFFF);
    cyc();
    interrupt = 1'b1;
    cyc();
    chk("isr_epc", 32'(epc), 32'h1);
    reset = 1'b1;
    cyc();
    chk("mid_rst_pc",  32'(current_address), 32'h0);
    chk("mid_rst_ia",  32'(int_active),      32'h0);
    chk("mid_rst_epc", 32'(epc),             32'h0);
    reset = 1'b0; interrupt = 1'b0;
    cyc(3);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
